// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared FSM state types and default timeout for the UART command wrapper.
package cmd_pkg;

  typedef enum logic {
    WAIT_HIGH = 1'b0,
    WAIT_LOW  = 1'b1
  } rx_state_t;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_BUSY = 1'b1
  } tx_state_t;

  // Four byte times at 50 MHz / 19200 baud.
  localparam int unsigned TIMEOUT_CYC_DEF = 104160;

endpackage

// File: rtl/cmd_timeout_cntr.sv
// rtl/cmd_timeout_cntr.sv - inter-byte timeout counter; expired once the count reaches TIMEOUT_CYC-1.
module cmd_timeout_cntr #(
  parameter int unsigned TIMEOUT_CYC = 104160,
  parameter int unsigned TO_W        = $clog2(TIMEOUT_CYC)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_cmd_wrapper.sv
// rtl/uart_cmd_wrapper.sv - assembles two UART bytes into a 16-bit command and returns one response byte.
// Optional inter-byte timeout with frame_err pulse enabled by `define CMD_TIMEOUT_EN.
module uart_cmd_wrapper
  import cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  output logic        resp_busy,
  output logic        frame_err
);

  rx_state_t   rx_state_q, rx_state_d;
  tx_state_t   tx_state_q, tx_state_d;
  logic [7:0]  high_q, high_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        trmt_q, trmt_d;
  logic        busy_q, busy_d;
  logic        expired;

  assign clr_rx_rdy = rx_rdy;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);

  cmd_timeout_cntr #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear_i   ((rx_state_q == WAIT_HIGH) && rx_rdy),
    .enable_i  (rx_state_q == WAIT_LOW),
    .expired_o (expired)
  );
`else
  // Comparison is constant false; it only keeps TIMEOUT_CYC referenced in this build.
  assign expired = (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    rx_state_d  = rx_state_q;
    high_d      = high_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = clr_cmd_rdy ? 1'b0 : cmd_rdy_q;
    frame_err_d = 1'b0;
    case (rx_state_q)
      WAIT_HIGH: begin
        if (rx_rdy) begin
          high_d     = rx_data;
          cmd_rdy_d  = 1'b0;
          rx_state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        // A byte arriving on the expiry cycle still completes the command.
        if (rx_rdy) begin
          cmd_d      = {high_q, rx_data};
          cmd_rdy_d  = 1'b1;
          rx_state_d = WAIT_HIGH;
        end else if (expired) begin
          high_d      = 8'h00;
          frame_err_d = 1'b1;
          rx_state_d  = WAIT_HIGH;
        end
      end
      default: rx_state_d = WAIT_HIGH;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    trmt_d     = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (send_resp) begin
          tx_data_d  = resp;
          trmt_d     = 1'b1;
          busy_d     = 1'b1;
          tx_state_d = T_BUSY;
        end
      end
      T_BUSY: begin
        if (tx_done) begin
          busy_d     = 1'b0;
          tx_state_d = T_IDLE;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q  <= WAIT_HIGH;
      high_q      <= 8'h00;
      cmd_q       <= 16'h0000;
      cmd_rdy_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_state_q  <= T_IDLE;
      tx_data_q   <= 8'h00;
      trmt_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      high_q      <= high_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      frame_err_q <= frame_err_d;
      tx_state_q  <= tx_state_d;
      tx_data_q   <= tx_data_d;
      trmt_q      <= trmt_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign frame_err = frame_err_q;
  assign tx_data   = tx_data_q;
  assign trmt      = trmt_q;
  assign resp_busy = busy_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb/tb_uart_cmd_wrapper.sv - directed self-checking bench for uart_cmd_wrapper.
module tb_uart_cmd_wrapper;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TCYC = 100;
`else
  localparam int unsigned TCYC = 104160;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        resp_busy;
  logic        frame_err;

  int n_cmp = 0;
  int n_err = 0;
  int fe_seen;

  always #5 clk = ~clk;

  uart_cmd_wrapper #(.TIMEOUT_CYC(TCYC)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_rdy      (rx_rdy),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .tx_data     (tx_data),
    .trmt        (trmt),
    .tx_done     (tx_done),
    .resp_busy   (resp_busy),
    .frame_err   (frame_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rx_data     = 8'($urandom);
      rx_rdy      = 1'($urandom);
      clr_cmd_rdy = 1'($urandom);
      resp        = 8'($urandom);
      send_resp   = 1'($urandom);
      tx_done     = 1'($urandom);
      tick();
    end
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
    chk("rst_trmt", {15'd0, trmt}, 16'd0);
    chk("rst_tx_data", {8'd0, tx_data}, 16'h0000);
    chk("rst_resp_busy", {15'd0, resp_busy}, 16'd0);
    chk("rst_frame_err", {15'd0, frame_err}, 16'd0);
    rst = 1'b0; rx_data = 8'h00; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
    resp = 8'h00; send_resp = 1'b0; tx_done = 1'b0;
    tick();

    rx_data = 8'hA5; rx_rdy = 1'b1;
    #1;
    chk("clr_rx_rdy_comb", {15'd0, clr_rx_rdy}, 16'd1);
    tick();
    rx_rdy = 1'b0;
    #1;
    chk("clr_rx_rdy_low", {15'd0, clr_rx_rdy}, 16'd0);
    for (int i = 0; i < 19; i++) tick();
    chk("full_wait_rdy", {15'd0, cmd_rdy}, 16'd0);
    send_byte(8'h3C);
    chk("full_cmd", cmd, 16'hA53C);
    chk("full_rdy", {15'd0, cmd_rdy}, 16'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("full_rdy_hold", {15'd0, cmd_rdy}, 16'd1);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    chk("full_rdy_clr", {15'd0, cmd_rdy}, 16'd0);
    chk("full_cmd_hold", cmd, 16'hA53C);

    send_byte(8'h12); send_byte(8'h34);
    chk("b2b_cmd1", cmd, 16'h1234);
    chk("b2b_rdy1", {15'd0, cmd_rdy}, 16'd1);
    send_byte(8'hFF);
    chk("b2b_high_rdy", {15'd0, cmd_rdy}, 16'd0);
    chk("b2b_high_cmd", cmd, 16'h1234);
    send_byte(8'h00);
    chk("b2b_cmd2", cmd, 16'hFF00);
    chk("b2b_rdy2", {15'd0, cmd_rdy}, 16'd1);

    send_byte(8'h5A);
    clr_cmd_rdy = 1'b1;
    send_byte(8'hC3);
    clr_cmd_rdy = 1'b0;
    chk("coll_rdy", {15'd0, cmd_rdy}, 16'd1);
    chk("coll_cmd", cmd, 16'h5AC3);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;

    resp = 8'hA5; send_resp = 1'b1; tick(); send_resp = 1'b0;
    chk("tx_data", {8'd0, tx_data}, 16'h00A5);
    chk("tx_trmt", {15'd0, trmt}, 16'd1);
    chk("tx_busy", {15'd0, resp_busy}, 16'd1);
    tick();
    chk("tx_trmt_pulse", {15'd0, trmt}, 16'd0);
    chk("tx_busy_hold", {15'd0, resp_busy}, 16'd1);
    resp = 8'h11; send_resp = 1'b1; tick(); send_resp = 1'b0;
    chk("tx_busy_trmt", {15'd0, trmt}, 16'd0);
    chk("tx_busy_data", {8'd0, tx_data}, 16'h00A5);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk("tx_done_busy", {15'd0, resp_busy}, 16'd0);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk("tx_idle_done", {15'd0, resp_busy}, 16'd0);
    chk("tx_idle_trmt", {15'd0, trmt}, 16'd0);

    resp = 8'h77; send_resp = 1'b1;
    send_byte(8'h9E);
    send_resp = 1'b0;
    chk("sim_trmt", {15'd0, trmt}, 16'd1);
    chk("sim_tx_data", {8'd0, tx_data}, 16'h0077);
    send_byte(8'h01);
    chk("sim_cmd", cmd, 16'h9E01);
    chk("sim_busy", {15'd0, resp_busy}, 16'd1);

    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_busy", {15'd0, resp_busy}, 16'd0);
    send_byte(8'h99);
    rst = 1'b1; tick(); rst = 1'b0;
    send_byte(8'h44); send_byte(8'h55);
    chk("rst_mid_cmd", cmd, 16'h4455);
    chk("rst_mid_rdy", {15'd0, cmd_rdy}, 16'd1);

`ifdef CMD_TIMEOUT_EN
    send_byte(8'h12);
    fe_seen = 0;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (frame_err) fe_seen++;
    end
    chk("to_early", 16'(fe_seen), 16'd0);
    tick();
    chk("to_pulse", {15'd0, frame_err}, 16'd1);
    tick();
    chk("to_pulse_end", {15'd0, frame_err}, 16'd0);
    send_byte(8'h56); send_byte(8'h78);
    chk("to_next_cmd", cmd, 16'h5678);
    chk("to_next_rdy", {15'd0, cmd_rdy}, 16'd1);
    send_byte(8'hAA);
    for (int i = 0; i < 99; i++) tick();
    send_byte(8'hBB);
    chk("to_edge_cmd", cmd, 16'hAABB);
    chk("to_edge_rdy", {15'd0, cmd_rdy}, 16'd1);
    chk("to_edge_fe", {15'd0, frame_err}, 16'd0);
    tick();
    chk("to_edge_fe2", {15'd0, frame_err}, 16'd0);
`else
    send_byte(8'h12);
    fe_seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (frame_err) fe_seen++;
    end
    chk("nto_frame_err", 16'(fe_seen), 16'd0);
    send_byte(8'h78);
    chk("nto_cmd", cmd, 16'h1278);
    chk("nto_rdy", {15'd0, cmd_rdy}, 16'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
